// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, register address width and the zero-register index.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;

endpackage : cpu_pkg

// File: rtl/register32.sv
// One architectural register: synchronous active-high clear, load when en is high.
module register32
  import cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : register32

// File: rtl/regfile_32x32.sv
// Register file with r0 hardwired to zero, one synchronous write port and two combinational read ports.
// Optional same-cycle write-to-read forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  import cpu_pkg::REG_ZERO;

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NREGS-1:0]  wr_sel;
  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_live;

  // r0 is never a write target, so its select bit stays low.
  assign wr_live = wr_en && (wr_addr != ZERO_ADDR);

  always_comb begin
    wr_sel = '0;
    if (wr_live) begin
      wr_sel[wr_addr] = 1'b1;
    end
  end

  assign regs[0] = '0;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      register32 #(
        .W (DATA_W)
      ) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (wr_sel[gi]),
        .d     (wr_data),
        .q     (regs[gi])
      );
    end
  endgenerate

  logic [DATA_W-1:0] stored_a;
  logic [DATA_W-1:0] stored_b;

  assign stored_a = (rd_addr_a == ZERO_ADDR) ? '0 : regs[rd_addr_a];
  assign stored_b = (rd_addr_b == ZERO_ADDR) ? '0 : regs[rd_addr_b];

`ifdef REGFILE_BYPASS_EN
  logic fwd_a;
  logic fwd_b;

  // wr_live already excludes r0, so r0 is never forwarded.
  assign fwd_a = wr_live && !reset && (rd_addr_a == wr_addr);
  assign fwd_b = wr_live && !reset && (rd_addr_b == wr_addr);

  assign rd_data_a = fwd_a ? wr_data : stored_a;
  assign rd_data_b = fwd_b ? wr_data : stored_b;
`else
  assign rd_data_a = stored_a;
  assign rd_data_b = stored_b;
`endif

endmodule : regfile_32x32

// File: tb/tb_regfile_32x32.sv
// Self-checking bench for regfile_32x32 against an array model of the register file.
// Same-cycle read expectations follow REGFILE_BYPASS_EN.
module tb_regfile_32x32;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  regfile_32x32 #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value a read port should show right now, given the model and the inputs being driven.
  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    logic [31:0] v;
    v = (addr == 5'd0) ? 32'h0 : model[addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !reset && wr_addr != 5'd0 && addr == wr_addr) v = wr_data;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s got %08h expected %08h", tag, got, exp);
      end
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [4:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
    #1;
    check($sformatf("%s_a[%0d]", tag, a), rd_data_a, exp_read(a));
    check($sformatf("%s_b[%0d]", tag, b), rd_data_b, exp_read(b));
  endtask

  // Clock edge plus model update from the inputs sampled at that edge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (wr_en && wr_addr != 5'd0) begin
      model[wr_addr] = wr_data;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = $urandom;
    model[0]  = 32'h0;
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'h0;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    step();
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      read_check("reset", 5'(i), 5'(31 - i));
      check($sformatf("reset_zero[%0d]", i), rd_data_a, 32'h0);
    end

    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    wr_en = 1'b0;
    read_check("w5", 5'd5, 5'd5);
    check("w5_const", rd_data_a, 32'hDEADBEEF);
    check("w5_same", rd_data_b, rd_data_a);
    read_check("w5_nbr", 5'd4, 5'd6);

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    read_check("r0_fwd", 5'd0, 5'd0);
    step();
    wr_en = 1'b0;
    read_check("r0", 5'd0, 5'd0);
    check("r0_const", rd_data_a, 32'h0);

    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h12345678;
    read_check("rst_fwd", 5'd31, 5'd5);
    step();
    reset = 1'b0; wr_en = 1'b0;
    read_check("r31_rst", 5'd31, 5'd5);
    check("r31_rst_const", rd_data_a, 32'h0);
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    read_check("r31_wr", 5'd31, 5'd31);
    check("r31_wr_const", rd_data_a, 32'h12345678);

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    read_check("byp7", 5'd7, 5'd6);
`ifdef REGFILE_BYPASS_EN
    check("byp7_const", rd_data_a, 32'hA5A5A5A5);
`else
    check("byp7_const", rd_data_a, 32'h0);
`endif
    step();
    wr_en = 1'b0;
    read_check("byp7_next", 5'd7, 5'd7);
    check("byp7_next_const", rd_data_a, 32'hA5A5A5A5);

    // Back-to-back writes to one register: the later edge wins.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11111111;
    step();
    wr_data = 32'h22222222;
    step();
    wr_en = 1'b0;
    read_check("b2b", 5'd9, 5'd9);
    check("b2b_const", rd_data_b, 32'h22222222);

    wr_en = 1'b1;
    for (int i = 1; i < 32; i++) begin
      wr_addr = 5'(i);
      wr_data = 32'(i) * 32'h01010101;
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) read_check("fill", 5'(i), 5'(i));

    for (int n = 0; n < 200; n++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        read_check("rnd", wr_addr, 5'($urandom_range(0, 31)));
      end else begin
        read_check("rnd", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) read_check("final", 5'(i), 5'(31 - i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_32x32
